ahbl_to_apb4_bridge: RTL and testbench
======================================

// Module: ahbl_to_apb4_bridge
// PURPOSE
//  AHB-Lite slave to APB4 master bridge, successor to the single-target APB bridge.
//  Decodes N_SLAVES psel lines and generates pstrb/pprot from hsize/haddr/hprot.
//  Adds a pready timeout that converts a hung access into an error response.
//  Sits between the SoC AHB-Lite crossbar and the peripheral APB segment; forwards hartid per transfer.
// PARAMETERS
//  W_HADDR 32 upstream address width
//  W_PADDR 16 per-slave APB address width (haddr[W_PADDR-1:0])
//  W_DATA 32 data width, 32 or 64; W_STRB=W_DATA/8
//  N_SLAVES 4 psel count, index=haddr[W_PADDR+W_SEL-1:W_PADDR], W_SEL=max(1,$clog2(N_SLAVES))
//  TIMEOUT 255 ACCESS cycles before forced error; 0 disables timeout
// PORTS
//  clk in 1 clock; rst in 1 synchronous active-high reset
//  ahbls_hready in 1; ahbls_hready_resp out 1; ahbls_hresp out 1
//  ahbls_haddr in W_HADDR; ahbls_hwrite in 1; ahbls_htrans in 2; ahbls_hsize in 3; ahbls_hprot in 4
//  ahbls_hwdata in W_DATA; ahbls_hrdata out W_DATA; ahbls_hartid in W_DATA
//  apbm_paddr out W_PADDR; apbm_psel out N_SLAVES (one-hot); apbm_penable out 1; apbm_pwrite out 1
//  apbm_pwdata out W_DATA; apbm_pstrb out W_STRB; apbm_pprot out 3; apbm_phartid out W_DATA
//  apbm_pready in 1; apbm_prdata in W_DATA; apbm_pslverr in 1
//  post_err out 1 sticky posted-write error; post_err_clr in 1 (both exist; inert without macro)
// BEHAVIOUR
//  Reset (sync, rst=1): state S_IDLE; all outputs 0 except ahbls_hready_resp=1; timeout counter 0.
//  Aphase accept: htrans[1]&&hready in S_IDLE/S_RESP/S_ERR1 -> latch paddr, sel idx, hwrite, hsize, hprot, hartid.
//  Decode error: idx>=N_SLAVES or hsize>log2(W_STRB) or haddr misaligned for hsize -> S_ERR0, no APB access.
//  States: S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_RESP, S_ERR0, S_ERR1.
//   IDLE/RESP/ERR1 --valid write--> WDATA (capture hwdata) -> SETUP; --valid read--> SETUP; else IDLE.
//   SETUP: psel[idx]=1, penable=0, 1 cycle -> ACCESS.
//   ACCESS: psel[idx]=1, penable=1; pready&&!pslverr -> RESP; pready&&pslverr -> ERR0;
//     counter==TIMEOUT (TIMEOUT!=0) and !pready -> drop psel, ERR0. Counter clears on SETUP entry.
//  hready_resp=1 in IDLE, RESP, ERR1; hresp=1 in ERR0, ERR1 (two-cycle AHB error).
//  Read latency: ahbls_hrdata registered from prdata on ACCESS&&pready; minimum 3 wait states (4 total cycles).
//  Write latency: min 4 wait states (WDATA, SETUP, ACCESS, RESP response cycle).
//  pstrb: read -> 0; write -> size mask shifted by haddr[log2(W_STRB)-1:0].
//  pprot = {~hprot[0], 1'b0, hprot[1]} (instruction, secure, privileged).
//  paddr/pwrite/pwdata/pstrb/pprot/phartid held stable from SETUP through ACCESS end.
//  Aphase with htrans[1]=0 or hready=0 in accepting states: ignored, no state change.
//  Timeout and pready coinciding: pready wins (normal completion).
// CONFIGURATION
//  Macro AHBL_TO_APB4_WPOST_EN (posted writes):
//   Defined: hready_resp=1 in S_WDATA; upstream write completes OKAY after hwdata capture.
//     A new aphase accepted in that cycle is held pending (hready_resp=0 until it is issued).
//     On write completion: pending write -> WDATA, pending read -> SETUP, none -> IDLE.
//     Posted-write pslverr/timeout sets post_err (no hresp); post_err_clr clears it; set wins on same cycle.
//   Undefined: writes non-posted as above; post_err tied 0; post_err_clr ignored.
// STRUCTURE
//  Package ahbl_apb_pkg: state encoding localparams, HTRANS/HSIZE codes, pprot bit indices,
//   strobe-mask function strb_from_size(hsize, addr_lsbs).
//  Sub-module apb_timeout_ctr (counter, clear, enable, expired flag) in the same directory.
// TESTING
//  Read slave 2, pready at 2nd ACCESS cycle, prdata=0xCAFEF00D -> psel=4'b0100, hrdata=0xCAFEF00D, hresp=0.
//  Byte write at haddr[1:0]=2'b11 data 0xAB000000 -> pstrb=4'b1000, pwdata=0xAB000000, pprot per hprot.
//  Access to index 5 with N_SLAVES=4 -> psel never asserted; hresp=1 for 2 cycles, 2nd with hready_resp=1.
//  pready held 0, TIMEOUT=8 -> psel drops after 8 ACCESS cycles; AHB error response follows.
//  Back-to-back write then read, pslverr=1 on write -> write gets error; read still issued, OKAY.
//  WPOST_EN: write, pslverr=1 -> OKAY upstream, post_err=1 until post_err_clr; trailing read stalled then completes.

Source files
------------

// File: rtl/ahbl_to_apb4_bridge_pkg.sv
// Shared encodings for the AHB-Lite to APB4 bridge: FSM states,
// AHB field codes, APB pprot bit positions and the strobe helper.
package ahbl_apb_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WDATA  = 3'd1;
  localparam logic [2:0] S_SETUP  = 3'd2;
  localparam logic [2:0] S_ACCESS = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;
  localparam logic [2:0] S_ERR0   = 3'd5;
  localparam logic [2:0] S_ERR1   = 3'd6;

  // htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY
  localparam int HTRANS_ACTIVE = 1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam int HPROT_DATA  = 0;
  localparam int HPROT_PRIV  = 1;
  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;

  function automatic logic [7:0] strb_from_size(
    input logic [2:0] hsize,
    input logic [2:0] addr_lsbs
  );
    logic [7:0] m;
    unique case (hsize)
      HSIZE_BYTE: m = 8'h01;
      HSIZE_HALF: m = 8'h03;
      HSIZE_WORD: m = 8'h0f;
      default:    m = 8'hff;
    endcase
    return m << addr_lsbs;
  endfunction

endpackage

// File: rtl/ahbl_to_apb4_bridge_timeout_ctr.sv
// apb_timeout_ctr: saturating ACCESS-cycle counter with expiry flag.
// Ports: clk_i, rst_i (sync, high), clr_i, en_i, expired_o. TIMEOUT=0 never expires.
module apb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counting through SETUP makes the value equal the number of
  // ACCESS cycles spent so far, including the current one.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && cnt_q != LIMIT)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/ahbl_to_apb4_bridge.sv
// AHB-Lite slave to multi-target APB4 master bridge with pready timeout.
// Ports: clk/rst (sync, high); ahbls_* upstream; apbm_* downstream;
// post_err/post_err_clr active only with AHBL_TO_APB4_WPOST_EN (posted writes).
module ahbl_to_apb4_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int W_HADDR  = 32,
  parameter int W_PADDR  = 16,
  parameter int W_DATA   = 32,
  parameter int N_SLAVES = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ahbls_hready,
  output logic                  ahbls_hready_resp,
  output logic                  ahbls_hresp,
  input  logic [W_HADDR-1:0]    ahbls_haddr,
  input  logic                  ahbls_hwrite,
  input  logic [1:0]            ahbls_htrans,
  input  logic [2:0]            ahbls_hsize,
  input  logic [3:0]            ahbls_hprot,
  input  logic [W_DATA-1:0]     ahbls_hwdata,
  output logic [W_DATA-1:0]     ahbls_hrdata,
  input  logic [W_DATA-1:0]     ahbls_hartid,
  output logic [W_PADDR-1:0]    apbm_paddr,
  output logic [N_SLAVES-1:0]   apbm_psel,
  output logic                  apbm_penable,
  output logic                  apbm_pwrite,
  output logic [W_DATA-1:0]     apbm_pwdata,
  output logic [W_DATA/8-1:0]   apbm_pstrb,
  output logic [2:0]            apbm_pprot,
  output logic [W_DATA-1:0]     apbm_phartid,
  input  logic                  apbm_pready,
  input  logic [W_DATA-1:0]     apbm_prdata,
  input  logic                  apbm_pslverr,
  output logic                  post_err,
  input  logic                  post_err_clr
);

  localparam int W_STRB = W_DATA / 8;
  localparam int W_SEL  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int W_LSB  = $clog2(W_STRB);
  localparam int W_UP   = W_HADDR - W_PADDR;
`ifdef AHBL_TO_APB4_WPOST_EN
  localparam bit WPOST = 1'b1;
`else
  localparam bit WPOST = 1'b0;
`endif

  logic [2:0] state_q, state_d;

  // Address-phase decode
  logic [W_UP-1:0]   dec_idx;
  logic [2:0]        dec_lsb;
  logic [7:0]        dec_amask;
  logic              dec_err;
  logic [W_STRB-1:0] dec_strb;
  logic [2:0]        dec_prot;

  always_comb begin
    // Everything above the per-slave window is the slot index, so
    // unmapped slots are caught even beyond the psel range.
    dec_idx = ahbls_haddr[W_HADDR-1:W_PADDR];
    dec_lsb = '0;
    dec_lsb[W_LSB-1:0] = ahbls_haddr[W_LSB-1:0];
    dec_amask = (8'd1 << ahbls_hsize) - 8'd1;
    dec_err = (dec_idx >= W_UP'(N_SLAVES))
           || (ahbls_hsize > 3'(W_LSB))
           || (|({5'd0, dec_lsb} & dec_amask));
    dec_strb = '0;
    if (ahbls_hwrite)
      dec_strb = W_STRB'(strb_from_size(ahbls_hsize, dec_lsb));
    dec_prot = '0;
    dec_prot[PPROT_INSTR] = ~ahbls_hprot[HPROT_DATA];
    dec_prot[PPROT_NSEC]  = 1'b0;
    dec_prot[PPROT_PRIV]  = ahbls_hprot[HPROT_PRIV];
  end

  logic unused_ahb;
  assign unused_ahb = ^{ahbls_hprot[3:2], ahbls_htrans[0]};

  // Active transfer
  logic [W_PADDR-1:0] act_addr_q;
  logic [W_SEL-1:0]   act_sel_q;
  logic               act_write_q;
  logic [W_STRB-1:0]  act_strb_q;
  logic [2:0]         act_prot_q;
  logic [W_DATA-1:0]  act_hartid_q;
  logic [W_DATA-1:0]  wdata_q;
  logic [W_DATA-1:0]  rdata_q;

  // Transfer taken while a posted write is still in flight
  logic               pnd_valid_q;
  logic               pnd_err_q;
  logic [W_PADDR-1:0] pnd_addr_q;
  logic [W_SEL-1:0]   pnd_sel_q;
  logic               pnd_write_q;
  logic [W_STRB-1:0]  pnd_strb_q;
  logic [2:0]         pnd_prot_q;
  logic [W_DATA-1:0]  pnd_hartid_q;

  logic req, accepting, load_bus, pnd_load, pnd_issue;
  logic expired, acc_end, acc_fail, act_posted;

  assign req        = ahbls_htrans[HTRANS_ACTIVE] && ahbls_hready;
  assign accepting  = state_q inside {S_IDLE, S_RESP, S_ERR1};
  assign load_bus   = accepting && req;
  assign act_posted = WPOST && act_write_q;
  assign acc_end    = (state_q == S_ACCESS)
                   && (apbm_pready || expired);
  // pready wins over a coinciding timeout
  assign acc_fail   = apbm_pready ? apbm_pslverr : 1'b1;
  assign pnd_load   = WPOST && (state_q == S_WDATA) && req;
  assign pnd_issue  = acc_end && act_posted && pnd_valid_q;

  apb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (state_d == S_SETUP),
    .en_i     (state_q == S_SETUP || state_q == S_ACCESS),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_RESP, S_ERR1: begin
        if (!req)         state_d = S_IDLE;
        else if (dec_err) state_d = S_ERR0;
        else if (ahbls_hwrite) state_d = S_WDATA;
        else              state_d = S_SETUP;
      end
      S_WDATA: state_d = S_SETUP;
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (acc_end) begin
          if (!act_posted)
            state_d = acc_fail ? S_ERR0 : S_RESP;
          else if (!pnd_valid_q) state_d = S_IDLE;
          else if (pnd_err_q)    state_d = S_ERR0;
          else if (pnd_write_q)  state_d = S_WDATA;
          else                   state_d = S_SETUP;
        end
      end
      S_ERR0:  state_d = S_ERR1;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ahbls_hready_resp = 1'b0;
    ahbls_hresp       = 1'b0;
    apbm_psel         = '0;
    apbm_penable      = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: ahbls_hready_resp = 1'b1;
      S_WDATA:  ahbls_hready_resp = WPOST;
      S_SETUP:  apbm_psel = N_SLAVES'(1) << act_sel_q;
      S_ACCESS: begin
        apbm_psel    = N_SLAVES'(1) << act_sel_q;
        apbm_penable = 1'b1;
      end
      S_ERR0:   ahbls_hresp = 1'b1;
      S_ERR1: begin
        ahbls_hresp       = 1'b1;
        ahbls_hready_resp = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_addr_q   <= '0;
      act_sel_q    <= '0;
      act_write_q  <= 1'b0;
      act_strb_q   <= '0;
      act_prot_q   <= '0;
      act_hartid_q <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      pnd_valid_q  <= 1'b0;
      pnd_err_q    <= 1'b0;
      pnd_addr_q   <= '0;
      pnd_sel_q    <= '0;
      pnd_write_q  <= 1'b0;
      pnd_strb_q   <= '0;
      pnd_prot_q   <= '0;
      pnd_hartid_q <= '0;
    end else begin
      if (load_bus) begin
        act_addr_q   <= ahbls_haddr[W_PADDR-1:0];
        act_sel_q    <= dec_idx[W_SEL-1:0];
        act_write_q  <= ahbls_hwrite;
        act_strb_q   <= dec_strb;
        act_prot_q   <= dec_prot;
        act_hartid_q <= ahbls_hartid;
      end else if (pnd_issue) begin
        act_addr_q   <= pnd_addr_q;
        act_sel_q    <= pnd_sel_q;
        act_write_q  <= pnd_write_q;
        act_strb_q   <= pnd_strb_q;
        act_prot_q   <= pnd_prot_q;
        act_hartid_q <= pnd_hartid_q;
      end
      if (state_q == S_WDATA)
        wdata_q <= ahbls_hwdata;
      if (state_q == S_ACCESS && apbm_pready)
        rdata_q <= apbm_prdata;
      if (pnd_load) begin
        pnd_valid_q  <= 1'b1;
        pnd_err_q    <= dec_err;
        pnd_addr_q   <= ahbls_haddr[W_PADDR-1:0];
        pnd_sel_q    <= dec_idx[W_SEL-1:0];
        pnd_write_q  <= ahbls_hwrite;
        pnd_strb_q   <= dec_strb;
        pnd_prot_q   <= dec_prot;
        pnd_hartid_q <= ahbls_hartid;
      end else if (pnd_issue || (acc_end && act_posted)) begin
        pnd_valid_q  <= 1'b0;
      end
    end
  end

  assign ahbls_hrdata = rdata_q;
  assign apbm_paddr   = act_addr_q;
  assign apbm_pwrite  = act_write_q;
  assign apbm_pwdata  = wdata_q;
  assign apbm_pstrb   = act_strb_q;
  assign apbm_pprot   = act_prot_q;
  assign apbm_phartid = act_hartid_q;

`ifdef AHBL_TO_APB4_WPOST_EN
  logic post_err_q, post_err_d;

  // A new error in the same cycle as a clear stays visible
  always_comb begin
    post_err_d = post_err_q;
    if (post_err_clr)
      post_err_d = 1'b0;
    if (acc_end && act_posted && acc_fail)
      post_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) post_err_q <= 1'b0;
    else     post_err_q <= post_err_d;
  end

  assign post_err = post_err_q;
`else
  logic unused_post_err_clr;
  assign unused_post_err_clr = post_err_clr;
  assign post_err = 1'b0;
`endif

endmodule

// File: tb/tb_ahbl_to_apb4_bridge.sv
// Directed self-checking bench for ahbl_to_apb4_bridge (TIMEOUT=8).
// Posted-write steps run only when AHBL_TO_APB4_WPOST_EN is defined.
module tb_ahbl_to_apb4_bridge;

`ifdef AHBL_TO_APB4_WPOST_EN
  localparam bit WPOST = 1'b1;
`else
  localparam bit WPOST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ahbls_hready;
  logic        ahbls_hready_resp;
  logic        ahbls_hresp;
  logic [31:0] ahbls_haddr;
  logic        ahbls_hwrite;
  logic [1:0]  ahbls_htrans;
  logic [2:0]  ahbls_hsize;
  logic [3:0]  ahbls_hprot;
  logic [31:0] ahbls_hwdata;
  logic [31:0] ahbls_hrdata;
  logic [31:0] ahbls_hartid;
  logic [15:0] apbm_paddr;
  logic [3:0]  apbm_psel;
  logic        apbm_penable;
  logic        apbm_pwrite;
  logic [31:0] apbm_pwdata;
  logic [3:0]  apbm_pstrb;
  logic [2:0]  apbm_pprot;
  logic [31:0] apbm_phartid;
  logic        apbm_pready;
  logic [31:0] apbm_prdata;
  logic        apbm_pslverr;
  logic        post_err;
  logic        post_err_clr;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ahbl_to_apb4_bridge #(
    .W_HADDR(32), .W_PADDR(16), .W_DATA(32),
    .N_SLAVES(4), .TIMEOUT(8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ahbls_hready     (ahbls_hready),
    .ahbls_hready_resp(ahbls_hready_resp),
    .ahbls_hresp      (ahbls_hresp),
    .ahbls_haddr      (ahbls_haddr),
    .ahbls_hwrite     (ahbls_hwrite),
    .ahbls_htrans     (ahbls_htrans),
    .ahbls_hsize      (ahbls_hsize),
    .ahbls_hprot      (ahbls_hprot),
    .ahbls_hwdata     (ahbls_hwdata),
    .ahbls_hrdata     (ahbls_hrdata),
    .ahbls_hartid     (ahbls_hartid),
    .apbm_paddr       (apbm_paddr),
    .apbm_psel        (apbm_psel),
    .apbm_penable     (apbm_penable),
    .apbm_pwrite      (apbm_pwrite),
    .apbm_pwdata      (apbm_pwdata),
    .apbm_pstrb       (apbm_pstrb),
    .apbm_pprot       (apbm_pprot),
    .apbm_phartid     (apbm_phartid),
    .apbm_pready      (apbm_pready),
    .apbm_prdata      (apbm_prdata),
    .apbm_pslverr     (apbm_pslverr),
    .post_err         (post_err),
    .post_err_clr     (post_err_clr)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic w,
                    input logic [2:0] s, input logic [3:0] p);
    ahbls_htrans = 2'b10;
    ahbls_haddr  = a;
    ahbls_hwrite = w;
    ahbls_hsize  = s;
    ahbls_hprot  = p;
    step();
    ahbls_htrans = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ahbls_hready = 1'b1;
    ahbls_haddr = '0;
    ahbls_hwrite = 1'b0;
    ahbls_htrans = 2'b00;
    ahbls_hsize = 3'd0;
    ahbls_hprot = 4'd0;
    ahbls_hwdata = '0;
    ahbls_hartid = '0;
    apbm_pready = 1'b0;
    apbm_prdata = '0;
    apbm_pslverr = 1'b0;
    post_err_clr = 1'b0;
    step();
    step();

    chk("rst_hready_resp", ahbls_hready_resp, 1);
    chk("rst_hresp", ahbls_hresp, 0);
    chk("rst_psel_pen", {apbm_psel, apbm_penable}, 0);
    chk("rst_hrdata", ahbls_hrdata, 0);
    chk("rst_pstrb_pprot", {apbm_pstrb, apbm_pprot}, 0);
    chk("rst_paddr", apbm_paddr, 0);
    chk("rst_post_err", post_err, 0);
    rst = 1'b0;
    step();

    // IDLE htrans and hready=0 must both be ignored
    ahbls_haddr = 32'h0002_0000;
    step();
    chk("idle_ignored", {ahbls_hready_resp, apbm_psel}, 5'b1_0000);
    ahbls_htrans = 2'b10;
    ahbls_hready = 1'b0;
    step();
    chk("hready_low_ignored", {ahbls_hready_resp, apbm_psel}, 5'b1_0000);
    ahbls_htrans = 2'b00;
    ahbls_hready = 1'b1;

    // Read slave 2, pready on second ACCESS cycle
    ahbls_hartid = 32'h0000_0003;
    ap(32'h0002_0010, 1'b0, 3'd2, 4'b0011);
    chk("rd_setup", {apbm_psel, apbm_penable, ahbls_hready_resp}, 6'b0100_0_0);
    chk("rd_paddr", apbm_paddr, 16'h0010);
    chk("rd_pwrite_pstrb_pprot", {apbm_pwrite, apbm_pstrb, apbm_pprot}, 8'b0_0000_001);
    chk("rd_phartid", apbm_phartid, 32'h3);
    step();
    chk("rd_access1", {apbm_psel, apbm_penable}, 5'b0100_1);
    step();
    chk("rd_access2", {apbm_psel, apbm_penable}, 5'b0100_1);
    apbm_pready = 1'b1;
    apbm_prdata = 32'hCAFE_F00D;
    step();
    apbm_pready = 1'b0;
    chk("rd_resp", {ahbls_hready_resp, ahbls_hresp, apbm_psel}, 6'b10_0000);
    chk("rd_hrdata", ahbls_hrdata, 32'hCAFE_F00D);
    step();

    // Byte write to slave 1 at lane 3, instruction/privileged
    ap(32'h0001_0023, 1'b1, 3'd0, 4'b0010);
    ahbls_hwdata = 32'hAB00_0000;
    chk("bw_wdata_hready", {ahbls_hready_resp, apbm_psel}, {WPOST, 4'b0000});
    step();
    ahbls_hwdata = 32'h0;
    chk("bw_setup", {apbm_psel, apbm_pwrite, apbm_paddr}, {4'b0010, 1'b1, 16'h0023});
    chk("bw_pstrb_pprot", {apbm_pstrb, apbm_pprot}, 7'b1000_101);
    chk("bw_pwdata", apbm_pwdata, 32'hAB00_0000);
    apbm_pready = 1'b1;
    step();
    chk("bw_access", {apbm_penable, apbm_pwdata}, {1'b1, 32'hAB00_0000});
    step();
    apbm_pready = 1'b0;
    chk("bw_done", {ahbls_hready_resp, ahbls_hresp, apbm_psel}, 6'b10_0000);
    step();

    // Unmapped slot 5: two-cycle error, no APB access
    ap(32'h0005_0000, 1'b0, 3'd2, 4'b0011);
    chk("idx5_err0", {apbm_psel, ahbls_hresp, ahbls_hready_resp}, 6'b0000_10);
    step();
    chk("idx5_err1", {apbm_psel, ahbls_hresp, ahbls_hready_resp}, 6'b0000_11);
    step();
    chk("idx5_idle", {ahbls_hresp, ahbls_hready_resp}, 2'b01);

    // Misaligned halfword, then oversize doubleword
    ap(32'h0001_0001, 1'b0, 3'd1, 4'b0011);
    chk("misalign_err0", {apbm_psel, ahbls_hresp}, 5'b0000_1);
    step();
    step();
    ap(32'h0001_0000, 1'b0, 3'd3, 4'b0011);
    chk("oversize_err0", {apbm_psel, ahbls_hresp}, 5'b0000_1);
    step();
    step();

    // Timeout: pready held low for TIMEOUT=8 ACCESS cycles
    ap(32'h0000_0004, 1'b0, 3'd2, 4'b0011);
    for (int i = 1; i <= 8; i++) begin
      step();
      chk($sformatf("tmo_access%0d", i), {apbm_psel, apbm_penable}, 5'b0001_1);
    end
    step();
    chk("tmo_err0", {apbm_psel, ahbls_hresp, ahbls_hready_resp}, 6'b0000_10);
    step();
    chk("tmo_err1", {ahbls_hresp, ahbls_hready_resp}, 2'b11);
    step();

`ifndef AHBL_TO_APB4_WPOST_EN
    // Write with pslverr, then a read issued during the error response
    ap(32'h0003_0008, 1'b1, 3'd2, 4'b0001);
    ahbls_hwdata = 32'h1234_5678;
    step();
    apbm_pready = 1'b1;
    apbm_pslverr = 1'b1;
    step();
    chk("b2b_wr_access", {apbm_pstrb, apbm_pwdata}, {4'b1111, 32'h1234_5678});
    step();
    apbm_pready = 1'b0;
    apbm_pslverr = 1'b0;
    chk("b2b_wr_err0", {ahbls_hresp, ahbls_hready_resp, apbm_psel}, 6'b10_0000);
    ahbls_htrans = 2'b10;
    ahbls_haddr = 32'h0003_000C;
    ahbls_hwrite = 1'b0;
    ahbls_hsize = 3'd2;
    step();
    chk("b2b_wr_err1", {ahbls_hresp, ahbls_hready_resp}, 2'b11);
    step();
    ahbls_htrans = 2'b00;
    chk("b2b_rd_setup", {apbm_psel, apbm_pwrite, apbm_paddr}, {4'b1000, 1'b0, 16'h000C});
    apbm_pready = 1'b1;
    apbm_prdata = 32'h5A5A_1234;
    step();
    step();
    apbm_pready = 1'b0;
    chk("b2b_rd_resp", {ahbls_hresp, ahbls_hready_resp}, 2'b01);
    chk("b2b_rd_hrdata", ahbls_hrdata, 32'h5A5A_1234);
    post_err_clr = 1'b1;
    step();
    post_err_clr = 1'b0;
    chk("no_post_err", post_err, 0);
    step();
`else
    // Posted write with pslverr; read arrives during write data cycle
    ap(32'h0001_0000, 1'b1, 3'd2, 4'b0011);
    ahbls_hwdata = 32'hDEAD_BEEF;
    chk("pw_wdata_okay", {ahbls_hready_resp, ahbls_hresp}, 2'b10);
    ahbls_htrans = 2'b10;
    ahbls_haddr = 32'h0002_0004;
    ahbls_hwrite = 1'b0;
    ahbls_hsize = 3'd2;
    apbm_pready = 1'b1;
    apbm_pslverr = 1'b1;
    step();
    ahbls_htrans = 2'b00;
    chk("pw_setup", {ahbls_hready_resp, apbm_psel, apbm_pwrite}, 6'b0_0010_1);
    chk("pw_pwdata", {apbm_pstrb, apbm_pwdata}, {4'b1111, 32'hDEAD_BEEF});
    step();
    step();
    apbm_pready = 1'b0;
    apbm_pslverr = 1'b0;
    chk("pw_post_err_set", post_err, 1);
    chk("pw_rd_setup", {apbm_psel, apbm_pwrite, ahbls_hresp, ahbls_hready_resp, apbm_paddr},
        {4'b0100, 3'b000, 16'h0004});
    apbm_pready = 1'b1;
    apbm_prdata = 32'h0BAD_CAFE;
    step();
    step();
    apbm_pready = 1'b0;
    chk("pw_rd_resp", {ahbls_hready_resp, ahbls_hresp}, 2'b10);
    chk("pw_rd_hrdata", ahbls_hrdata, 32'h0BAD_CAFE);
    chk("pw_post_err_held", post_err, 1);
    post_err_clr = 1'b1;
    step();
    post_err_clr = 1'b0;
    chk("pw_post_err_clr", post_err, 0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
